// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: FSM states, halt causes,
// enable levels and exception request bits.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALT   = 2'b10,
        ST_RESUME = 2'b11
    } ctrl_state_e;

    localparam logic [1:0] HALT_NONE = 2'b00;
    localparam logic [1:0] HALT_ENV  = 2'b01;
    localparam logic [1:0] HALT_BP   = 2'b10;

    localparam logic STALL_EN  = 1'b1;
    localparam logic STALL_DIS = 1'b0;

    // Bit positions within the {bp_exception, env_exception} request vector.
    localparam logic [1:0] ENV_EXC = 2'b01;
    localparam logic [1:0] BP_EXC  = 2'b10;

endpackage

// File: rtl/pipeline_ctrl_perf_counter.sv
// Event counter with synchronous clear and hold; wraps modulo 2^CNT_WIDTH.
module perf_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc_i,
    input  logic                 clear_i,
    input  logic                 hold_i,
    output logic [CNT_WIDTH-1:0] count_o
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    // Clear beats both hold and a same-cycle increment.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && !hold_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline sequencer: turns stalls, redirects, memory wait and
// ID-stage exceptions into per-stage enables/flushes, with drain/halt/resume.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hazard_stall,
    input  logic                 branch_taken,
    input  logic                 env_exception,
    input  logic                 bp_exception,
    input  logic                 mem_wait,
    input  logic                 resume,
    input  logic                 cnt_clear,
    output logic                 pc_en,
    output logic                 ifid_en,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic                 back_en,
    output logic                 halted,
    output logic [1:0]           halt_cause,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [1:0]           dbg_state
);

    localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES);
    localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);

    ctrl_state_e   state_q, state_d;
    logic [DW-1:0] drain_q, drain_d;
    logic [1:0]    cause_q, cause_d;
    logic          halted_q, halted_d;
    logic          stall_inc;
    logic [1:0]    exc_vec;

    assign exc_vec = {bp_exception, env_exception};

    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        cause_d    = cause_q;
        pc_en      = STALL_EN;
        ifid_en    = STALL_EN;
        back_en    = STALL_EN;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        stall_inc  = 1'b0;

        if (rst) begin
            pc_en      = STALL_DIS;
            ifid_en    = STALL_DIS;
            back_en    = STALL_DIS;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (mem_wait) begin
            // Whole pipe frozen: nothing moves, nothing is counted.
            pc_en   = STALL_DIS;
            ifid_en = STALL_DIS;
            back_en = STALL_DIS;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if ((exc_vec & (ENV_EXC | BP_EXC)) != 2'b00) begin
                        pc_en      = STALL_DIS;
                        ifid_en    = STALL_DIS;
                        idex_flush = 1'b1;
                        cause_d    = ((exc_vec & BP_EXC) != 2'b00) ? HALT_BP : HALT_ENV;
                        drain_d    = DRAIN_LOAD;
                        state_d    = ST_DRAIN;
                    end else if (hazard_stall) begin
                        pc_en      = STALL_DIS;
                        ifid_en    = STALL_DIS;
                        idex_flush = 1'b1;
                        stall_inc  = 1'b1;
                    end else if (branch_taken) begin
                        ifid_flush = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Front stays frozen while EX/MEM/WB retire.
                    pc_en      = STALL_DIS;
                    ifid_en    = STALL_DIS;
                    idex_flush = 1'b1;
                    if (drain_q <= DRAIN_ONE) begin
                        drain_d = '0;
                        state_d = ST_HALT;
                    end else begin
                        drain_d = drain_q - 1'b1;
                    end
                end
                ST_HALT: begin
                    pc_en   = STALL_DIS;
                    ifid_en = STALL_DIS;
                    back_en = STALL_DIS;
                    if (resume) begin
                        state_d = ST_RESUME;
                    end
                end
                ST_RESUME: begin
                    // Drop the excepting instruction; PC already points past it.
                    pc_en      = STALL_DIS;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    cause_d    = HALT_NONE;
                    state_d    = ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    assign halted_d = (state_d == ST_HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            drain_q  <= '0;
            cause_q  <= HALT_NONE;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            cause_q  <= cause_d;
            halted_q <= halted_d;
        end
    end

    perf_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (stall_inc),
        .clear_i (cnt_clear),
        .hold_i  (mem_wait),
        .count_o (stall_count)
    );

    assign halted     = halted_q & ~rst;
    assign halt_cause = cause_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: scenario tasks with inline checks plus a
// stall_count scoreboard popped one cycle after each driven cycle.
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        hazard_stall, branch_taken, env_exception, bp_exception;
    logic        mem_wait, resume, cnt_clear;
    logic        pc_en, ifid_en, ifid_flush, idex_flush, back_en, halted;
    logic [1:0]  halt_cause, dbg_state;
    logic [31:0] stall_count;
    logic [4:0]  outs;

    // Narrow-counter copy sharing all stimulus, used to exercise wrap-around.
    logic        w_pc_en, w_ifid_en, w_ifid_flush, w_idex_flush, w_back_en, w_halted;
    logic [1:0]  w_halt_cause, w_dbg_state;
    logic [2:0]  w_stall_count;

    logic [31:0] exp_q[$];
    logic [31:0] model_cnt;
    int          checks;
    int          failures;

    localparam logic [4:0] RUNV   = 5'b11001;
    localparam logic [4:0] STALLV = 5'b00011;
    localparam logic [4:0] BRV    = 5'b11101;
    localparam logic [4:0] FRZV   = 5'b00011;
    localparam logic [4:0] ZEROV  = 5'b00000;
    localparam logic [4:0] RSTV   = 5'b00110;

    assign outs = {pc_en, ifid_en, ifid_flush, idex_flush, back_en};

    pipeline_ctrl #(.DRAIN_CYCLES(3), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .hazard_stall(hazard_stall), .branch_taken(branch_taken),
        .env_exception(env_exception), .bp_exception(bp_exception), .mem_wait(mem_wait),
        .resume(resume), .cnt_clear(cnt_clear), .pc_en(pc_en), .ifid_en(ifid_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .back_en(back_en),
        .halted(halted), .halt_cause(halt_cause), .stall_count(stall_count),
        .dbg_state(dbg_state)
    );

    pipeline_ctrl #(.DRAIN_CYCLES(3), .CNT_WIDTH(3)) dut_w (
        .clk(clk), .rst(rst), .hazard_stall(hazard_stall), .branch_taken(branch_taken),
        .env_exception(env_exception), .bp_exception(bp_exception), .mem_wait(mem_wait),
        .resume(resume), .cnt_clear(cnt_clear), .pc_en(w_pc_en), .ifid_en(w_ifid_en),
        .ifid_flush(w_ifid_flush), .idex_flush(w_idex_flush), .back_en(w_back_en),
        .halted(w_halted), .halt_cause(w_halt_cause), .stall_count(w_stall_count),
        .dbg_state(w_dbg_state)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst = 1'b1;
        hazard_stall = 1'b0; branch_taken = 1'b0; env_exception = 1'b0;
        bp_exception = 1'b0; mem_wait = 1'b0; resume = 1'b0; cnt_clear = 1'b0;
    end

    // Driver: one cycle of stimulus, applied at the falling edge, with the
    // stall_count expected after the following rising edge queued.
    task automatic drive(input logic r, input logic hz, input logic br, input logic env,
                         input logic bp, input logic mw, input logic res, input logic clr,
                         input logic exp_inc);
        @(negedge clk);
        rst = r; hazard_stall = hz; branch_taken = br; env_exception = env;
        bp_exception = bp; mem_wait = mw; resume = res; cnt_clear = clr;
        if (r || clr) model_cnt = '0;
        else if (exp_inc) model_cnt = model_cnt + 32'd1;
        exp_q.push_back(model_cnt);
    endtask

    // Scoreboard: compare stall_count on both instances after each edge.
    always @(posedge clk) begin
        logic [31:0] exp;
        #2;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            checks++;
            if (stall_count !== exp) begin
                failures++;
                $display("FAIL stall_count got=%0d exp=%0d t=%0t", stall_count, exp, $time);
            end
            checks++;
            if (w_stall_count !== exp[2:0]) begin
                failures++;
                $display("FAIL stall_count_wrap got=%0d exp=%0d t=%0t", w_stall_count, exp[2:0], $time);
            end
        end
    end

    task automatic test_reset;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        checks++;
        if (outs !== RSTV || halted !== 1'b0) begin
            failures++;
            $display("FAIL reset_outs got=%b halted=%b exp=%b halted=0", outs, halted, RSTV);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        checks++;
        if (dbg_state !== ST_RUN || halted !== 1'b0 || halt_cause !== HALT_NONE) begin
            failures++;
            $display("FAIL reset_state got=%0d/%b/%b exp=0/0/00", dbg_state, halted, halt_cause);
        end
        checks++;
        if (outs !== RUNV) begin
            failures++;
            $display("FAIL run_idle got=%b exp=%b", outs, RUNV);
        end
    endtask

    task automatic test_hazard;
        drive(0, 1, 0, 0, 0, 0, 0, 0, 1); #1;
        checks++;
        if (outs !== STALLV) begin
            failures++;
            $display("FAIL hazard_outs got=%b exp=%b", outs, STALLV);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        checks++;
        if (outs !== RUNV) begin
            failures++;
            $display("FAIL after_hazard got=%b exp=%b", outs, RUNV);
        end
    endtask

    task automatic test_branch;
        drive(0, 1, 1, 0, 0, 0, 0, 0, 1); #1;
        checks++;
        if (outs !== STALLV) begin
            failures++;
            $display("FAIL branch_with_stall got=%b exp=%b", outs, STALLV);
        end
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0); #1;
        checks++;
        if (outs !== BRV) begin
            failures++;
            $display("FAIL branch_alone got=%b exp=%b", outs, BRV);
        end
    endtask

    task automatic test_env;
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0); #1;
        checks++;
        if (outs !== FRZV || dbg_state !== ST_RUN) begin
            failures++;
            $display("FAIL env_detect got=%b st=%0d exp=%b st=0", outs, dbg_state, FRZV);
        end
        for (int i = 1; i <= 3; i++) begin
            // Hazard, branch and a new exception must all be ignored here.
            drive(0, 1, 1, 0, 1, 0, 0, 0, 0); #1;
            checks++;
            if (dbg_state !== ST_DRAIN || outs !== FRZV || halted !== 1'b0 || halt_cause !== HALT_ENV) begin
                failures++;
                $display("FAIL env_drain%0d got=st%0d %b h%b c%b exp=st1 %b h0 c01",
                         i, dbg_state, outs, halted, halt_cause, FRZV);
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        checks++;
        if (dbg_state !== ST_HALT || halted !== 1'b1 || outs !== ZEROV || halt_cause !== HALT_ENV) begin
            failures++;
            $display("FAIL env_halt got=st%0d h%b %b c%b exp=st2 h1 %b c01",
                     dbg_state, halted, outs, halt_cause, ZEROV);
        end
        repeat (4) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0); #1;
        checks++;
        if (dbg_state !== ST_HALT || outs !== ZEROV) begin
            failures++;
            $display("FAIL env_hold got=st%0d %b exp=st2 %b", dbg_state, outs, ZEROV);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        checks++;
        if (dbg_state !== ST_RESUME || {pc_en, ifid_flush, idex_flush, back_en} !== 4'b0111
            || halted !== 1'b0) begin
            failures++;
            $display("FAIL env_resume got=st%0d %b h%b exp=st3 pc0 iff1 idf1 be1 h0",
                     dbg_state, outs, halted);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        checks++;
        if (dbg_state !== ST_RUN || halt_cause !== HALT_NONE || outs !== RUNV) begin
            failures++;
            $display("FAIL env_rerun got=st%0d c%b %b exp=st0 c00 %b",
                     dbg_state, halt_cause, outs, RUNV);
        end
    endtask

    task automatic test_bp_memwait;
        // Both causes at once: breakpoint code must win.
        drive(0, 1, 0, 1, 1, 0, 0, 0, 0); #1;
        checks++;
        if (outs !== FRZV) begin
            failures++;
            $display("FAIL bp_detect got=%b exp=%b", outs, FRZV);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        checks++;
        if (dbg_state !== ST_DRAIN || outs !== FRZV || halt_cause !== HALT_BP) begin
            failures++;
            $display("FAIL bp_drain1 got=st%0d %b c%b exp=st1 %b c10", dbg_state, outs, halt_cause, FRZV);
        end
        repeat (2) begin
            drive(0, 0, 0, 0, 0, 1, 0, 0, 0); #1;
            checks++;
            if (dbg_state !== ST_DRAIN || outs !== ZEROV) begin
                failures++;
                $display("FAIL bp_wait got=st%0d %b exp=st1 %b", dbg_state, outs, ZEROV);
            end
        end
        repeat (2) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
            checks++;
            if (dbg_state !== ST_DRAIN || outs !== FRZV) begin
                failures++;
                $display("FAIL bp_drain got=st%0d %b exp=st1 %b", dbg_state, outs, FRZV);
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        checks++;
        if (dbg_state !== ST_HALT || halted !== 1'b1 || halt_cause !== HALT_BP) begin
            failures++;
            $display("FAIL bp_halt got=st%0d h%b c%b exp=st2 h1 c10", dbg_state, halted, halt_cause);
        end
    endtask

    task automatic test_reset_in_halt;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        checks++;
        if (outs !== RSTV || halted !== 1'b0) begin
            failures++;
            $display("FAIL rst_halt_outs got=%b h%b exp=%b h0", outs, halted, RSTV);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        checks++;
        if (dbg_state !== ST_RUN || halted !== 1'b0 || halt_cause !== HALT_NONE || outs !== RUNV) begin
            failures++;
            $display("FAIL rst_halt_after got=st%0d h%b c%b %b exp=st0 h0 c00 %b",
                     dbg_state, halted, halt_cause, outs, RUNV);
        end
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0); #1;
        checks++;
        if (outs !== RUNV) begin
            failures++;
            $display("FAIL resume_in_run got=%b exp=%b", outs, RUNV);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        checks++;
        if (dbg_state !== ST_RUN) begin
            failures++;
            $display("FAIL resume_in_run_state got=%0d exp=0", dbg_state);
        end
    endtask

    task automatic test_wrap_clear;
        int n;
        n = $urandom_range(9, 12);
        for (int i = 0; i < n; i++) begin
            drive(0, 1, $urandom_range(0, 1), 0, 0, 0, 0, 0, 1); #1;
            checks++;
            if (outs !== STALLV) begin
                failures++;
                $display("FAIL wrap_bubble%0d got=%b exp=%b", i, outs, STALLV);
            end
        end
        drive(0, 1, 0, 0, 0, 0, 0, 1, 1); #1;
        drive(0, 1, 0, 0, 0, 1, 0, 0, 0); #1;
        checks++;
        if (outs !== ZEROV) begin
            failures++;
            $display("FAIL memwait_run got=%b exp=%b", outs, ZEROV);
        end
        drive(0, 1, 0, 0, 0, 0, 0, 0, 1); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        model_cnt = '0;
        test_reset();
        test_hazard();
        test_branch();
        test_env();
        test_bp_memwait();
        test_reset_in_halt();
        test_wrap_clear();
        repeat (2) @(posedge clk);
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
